seq_game_core: RTL and testbench

Parametrised successor to the sequence-memory game datapath, running fully synchronously on one clock.
- Generates a pseudo-random sequence of DEPTH patterns, each WIDTH bits, from a seed.
- Plays entries 0..level back on the LEDs, paced by a tick, with a blank gap between entries.
- Checks the player's switch guesses, then advances the level, fails, or declares a win.
- Sits between the debounced key/switch front end and the LED/7-segment display logic.

---
 rtl/seq_game_pkg.sv | 11 +
 rtl/seq_game_if.sv | 22 ++
 rtl/seq_game_mem.sv | 22 ++
 rtl/seq_game_core.sv | 123 ++++++++++++
 tb/tb_seq_game_core.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seq_game_pkg.sv
// seq_game_pkg: shared state encoding, generator step and constants for the sequence game
package seq_game_pkg;
  typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, WIN} state_t;
  localparam int SEED_ZERO_SUB = 1;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] next_pattern(input logic [MAX_W-1:0] x, input int width);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    return (x ^ (x << 1) ^ (x << 5)) & mask;
  endfunction
endpackage

// File: rtl/seq_game_if.sv
// seq_game_if: player/display side bus of the sequence game core
interface seq_game_if #(
  parameter int WIDTH = 10,
  parameter int LVL_W = 4
);
  logic tick;
  logic start_p;
  logic confirm_p;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] guess;
  logic [WIDTH-1:0] led;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] idx;
  logic pass_o;
  logic fail_o;
  logic win_o;
  logic busy;
  modport master(output tick, start_p, confirm_p, seed, guess,
                 input led, level, idx, pass_o, fail_o, win_o, busy);
  modport slave(input tick, start_p, confirm_p, seed, guess,
                output led, level, idx, pass_o, fail_o, win_o, busy);
endinterface

// File: rtl/seq_game_mem.sv
// seq_game_mem: sequence storage with one sync write port and two async read ports
module seq_game_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LVL_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [LVL_W-1:0] raddr_play,
  output logic [WIDTH-1:0] rdata_play,
  input  logic [LVL_W-1:0] raddr_cmp,
  output logic [WIDTH-1:0] rdata_cmp
);
  logic [WIDTH-1:0] mem [DEPTH];
  // contents survive reset so a restart can replay without regenerating
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata_play = mem[raddr_play];
  assign rdata_cmp = mem[raddr_cmp];
endmodule

// File: rtl/seq_game_core.sv
// seq_game_core: generates, plays back and checks the sequence-memory game
module seq_game_core
  import seq_game_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int FAIL_REGEN = 0
) (
  input logic clk,
  input logic rst,
  seq_game_if.slave bus
);
  localparam int LVL_W = $clog2(DEPTH);
  state_t state, nstate;
  logic [WIDTH-1:0] x, led_r, rd_play, rd_cmp, seed0;
  logic [LVL_W-1:0] gcnt, level_r, idx_r;
  logic pass_r, fail_r, win_r;
  logic start, hit, gen_last, lvl_last, idx_last;
  assign start = bus.start_p && state != GEN;
  assign hit = bus.guess == rd_cmp;
  assign gen_last = gcnt == LVL_W'(DEPTH - 1);
  assign lvl_last = level_r == LVL_W'(DEPTH - 1);
  assign idx_last = idx_r == level_r;
  assign seed0 = (bus.seed == '0) ? WIDTH'(SEED_ZERO_SUB) : bus.seed;
  seq_game_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_mem (
    .clk(clk),
    .we(state == GEN),
    .waddr(gcnt),
    .wdata(x),
    .raddr_play(idx_r),
    .rdata_play(rd_play),
    .raddr_cmp(idx_r),
    .rdata_cmp(rd_cmp)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nstate;
  // next state; start wins over everything except an ongoing generation
  always_comb begin
    nstate = state;
    if (start) nstate = GEN;
    else
      case (state)
        GEN:      if (gen_last) nstate = SHOW_ON;
        SHOW_ON:  if (bus.tick) nstate = SHOW_OFF;
        SHOW_OFF: if (bus.tick) nstate = idx_last ? INPUT : SHOW_ON;
        INPUT:    if (bus.confirm_p)
                    nstate = !hit ? ((FAIL_REGEN != 0) ? GEN : SHOW_ON)
                           : !idx_last ? INPUT : lvl_last ? WIN : SHOW_ON;
        default:  ;
      endcase
  end
  // datapath: generator, level/index tracking, playback pattern and flags
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      gcnt <= '0;
      level_r <= '0;
      idx_r <= '0;
      led_r <= '0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
      win_r <= 1'b0;
    end else if (start) begin
      x <= seed0;
      gcnt <= '0;
      level_r <= '0;
      idx_r <= '0;
      led_r <= '0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
      win_r <= 1'b0;
    end else
      case (state)
        GEN: begin
          x <= WIDTH'(next_pattern(MAX_W'(x), WIDTH));
          gcnt <= gen_last ? '0 : gcnt + 1'b1;
          if (gen_last) begin
            idx_r <= '0;
            led_r <= '0;
          end
        end
        SHOW_ON: if (bus.tick) led_r <= rd_play;
        SHOW_OFF:
          if (bus.tick) begin
            led_r <= '0;
            idx_r <= idx_last ? '0 : idx_r + 1'b1;
          end
        INPUT:
          if (bus.confirm_p) begin
            pass_r <= 1'b0;
            fail_r <= 1'b0;
            if (!hit) begin
              fail_r <= 1'b1;
              level_r <= '0;
              idx_r <= '0;
              if (FAIL_REGEN != 0) begin
                x <= seed0;
                gcnt <= '0;
              end
            end else if (!idx_last) idx_r <= idx_r + 1'b1;
            else if (lvl_last) begin
              win_r <= 1'b1;
              led_r <= '1;
            end else begin
              pass_r <= 1'b1;
              level_r <= level_r + 1'b1;
              idx_r <= '0;
            end
          end
        default: ;
      endcase
  // outputs
  always_comb begin
    bus.busy = state == GEN || state == SHOW_ON || state == SHOW_OFF;
    bus.led = led_r;
    bus.level = level_r;
    bus.idx = idx_r;
    bus.pass_o = pass_r;
    bus.fail_o = fail_r;
    bus.win_o = win_r;
  end
endmodule

// File: tb/tb_seq_game_core.sv
// tb_seq_game_core: directed checks of the sequence game on two parameter sets
module tb_seq_game_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic tk[2], st[2], cf[2];
  logic [9:0] sd[2], gs[2];
  logic [9:0] led[2];
  logic [3:0] lvl[2], ix[2];
  logic ps[2], fl[2], wn[2], by[2];
  logic [9:0] seqa[4] = '{10'h001, 10'h023, 10'h005, 10'h0AF};
  seq_game_if #(.WIDTH(10), .LVL_W(2)) i0 ();
  seq_game_if #(.WIDTH(10), .LVL_W(4)) i1 ();
  seq_game_core #(.WIDTH(10), .DEPTH(4), .FAIL_REGEN(0)) d0 (.clk(clk), .rst(rst), .bus(i0));
  seq_game_core #(.WIDTH(10), .DEPTH(16), .FAIL_REGEN(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
  assign i0.tick = tk[0];
  assign i0.start_p = st[0];
  assign i0.confirm_p = cf[0];
  assign i0.seed = sd[0];
  assign i0.guess = gs[0];
  assign i1.tick = tk[1];
  assign i1.start_p = st[1];
  assign i1.confirm_p = cf[1];
  assign i1.seed = sd[1];
  assign i1.guess = gs[1];
  assign led[0] = i0.led;
  assign lvl[0] = {2'b00, i0.level};
  assign ix[0] = {2'b00, i0.idx};
  assign ps[0] = i0.pass_o;
  assign fl[0] = i0.fail_o;
  assign wn[0] = i0.win_o;
  assign by[0] = i0.busy;
  assign led[1] = i1.led;
  assign lvl[1] = i1.level;
  assign ix[1] = i1.idx;
  assign ps[1] = i1.pass_o;
  assign fl[1] = i1.fail_o;
  assign wn[1] = i1.win_o;
  assign by[1] = i1.busy;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input int k, input logic [9:0] s);
    sd[k] = s;
    st[k] = 1'b1;
    cyc();
    st[k] = 1'b0;
  endtask
  task automatic conf(input int k, input logic [9:0] g);
    gs[k] = g;
    cf[k] = 1'b1;
    cyc();
    cf[k] = 1'b0;
  endtask
  task automatic tick(input int k, input logic [9:0] e, input string tag);
    tk[k] = 1'b1;
    cyc();
    tk[k] = 1'b0;
    check(tag, led[k], e);
  endtask
  task automatic gen_wait(input int k, input int n, input bit glitch);
    for (int i = 1; i < n; i++) begin
      st[k] = glitch && i == 5;
      sd[k] = glitch ? 10'h2AA : sd[k];
      cyc();
      st[k] = 1'b0;
      check("gen_busy", by[k], 1);
    end
    tick(k, 10'h000, "gen_tick_ignored");
  endtask
  task automatic play(input int k, input int n);
    for (int i = 0; i <= n; i++) begin
      tick(k, seqa[i], "play_lit");
      tick(k, 10'h000, "play_dark");
    end
    check("play_end_busy", by[k], 0);
  endtask
  task automatic reset_state(input int k);
    check("rst_led", led[k], 0);
    check("rst_level", lvl[k], 0);
    check("rst_idx", ix[k], 0);
    check("rst_pass", ps[k], 0);
    check("rst_fail", fl[k], 0);
    check("rst_win", wn[k], 0);
    check("rst_busy", by[k], 0);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      tk[k] = 1'b0;
      st[k] = 1'b0;
      cf[k] = 1'b0;
      sd[k] = '0;
      gs[k] = '0;
    end
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) reset_state(k);
    rst = 1'b0;
    cyc();
    start(1, 10'h155);
    check("b_start_busy", by[1], 1);
    gen_wait(1, 16, 1'b1);
    tick(1, 10'h155, "b_first_entry");
    tick(1, 10'h000, "b_first_dark");
    sd[1] = 10'h000;
    conf(1, 10'h000);
    check("b_fail", fl[1], 1);
    check("b_fail_level", lvl[1], 0);
    check("b_regen_busy", by[1], 1);
    gen_wait(1, 16, 1'b0);
    tick(1, 10'h001, "b_regen_entry0");
    tick(1, 10'h000, "b_regen_dark");
    check("b_fail_sticky", fl[1], 1);
    conf(1, 10'h001);
    check("b_pass", ps[1], 1);
    check("b_fail_cleared", fl[1], 0);
    check("b_level1", lvl[1], 1);
    play(1, 1);
    start(0, 10'h001);
    gen_wait(0, 4, 1'b0);
    play(0, 0);
    conf(0, 10'h001);
    check("a_pass", ps[0], 1);
    check("a_level1", lvl[0], 1);
    check("a_idx0", ix[0], 0);
    play(0, 1);
    conf(0, 10'h001);
    check("a_pass_cleared", ps[0], 0);
    check("a_idx1", ix[0], 1);
    conf(0, 10'h3FF);
    check("a_fail", fl[0], 1);
    check("a_fail_level", lvl[0], 0);
    check("a_fail_idx", ix[0], 0);
    check("a_fail_busy", by[0], 1);
    play(0, 0);
    conf(0, 10'h001);
    check("a_relevel1", lvl[0], 1);
    play(0, 1);
    conf(0, 10'h001);
    conf(0, 10'h023);
    check("a_level2", lvl[0], 2);
    play(0, 2);
    for (int i = 0; i < 3; i++) conf(0, seqa[i]);
    check("a_level3", lvl[0], 3);
    play(0, 3);
    for (int i = 0; i < 4; i++) conf(0, seqa[i]);
    check("a_win", wn[0], 1);
    check("a_win_led", led[0], 10'h3FF);
    check("a_win_busy", by[0], 0);
    check("a_win_pass", ps[0], 0);
    conf(0, 10'h000);
    check("a_win_hold", wn[0], 1);
    check("a_win_no_fail", fl[0], 0);
    tick(0, 10'h3FF, "a_win_tick_ignored");
    start(0, 10'h000);
    check("a_restart_win", wn[0], 0);
    check("a_restart_level", lvl[0], 0);
    check("a_restart_busy", by[0], 1);
    gen_wait(0, 4, 1'b0);
    tick(0, 10'h001, "a_seed0_entry0");
    tick(0, 10'h000, "a_seed0_dark");
    gs[0] = 10'h001;
    cf[0] = 1'b1;
    sd[0] = 10'h001;
    st[0] = 1'b1;
    cyc();
    cf[0] = 1'b0;
    st[0] = 1'b0;
    check("a_both_level", lvl[0], 0);
    check("a_both_pass", ps[0], 0);
    check("a_both_fail", fl[0], 0);
    check("a_both_busy", by[0], 1);
    gen_wait(0, 4, 1'b0);
    play(0, 0);
    conf(0, 10'h001);
    tick(0, 10'h001, "a_pre_rst_lit");
    tick(0, 10'h000, "a_pre_rst_dark");
    check("a_pre_rst_idx", ix[0], 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    reset_state(0);
    tick(0, 10'h000, "a_idle_tick_ignored");
    check("a_idle_busy", by[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
